// File: rtl/mem_arbiter_if.sv
// Bus between mem_arbiter and its surroundings: fetch, data and debug requester ports
// plus the external SRAM pins. The master side is the requesters together with the SRAM.
interface mem_arbiter_if;
    logic        ifReq;
    logic [15:0] ifAddr;
    logic [15:0] ifRdata;
    logic        ifAck;

    logic        memReq;
    logic        memWr;
    logic [15:0] memAddr;
    logic [15:0] memWdata;
    logic [15:0] memRdata;
    logic        memAck;

    logic        dbgReq;
    logic        dbgWr;
    logic [15:0] dbgAddr;
    logic [15:0] dbgWdata;
    logic [15:0] dbgRdata;
    logic        dbgAck;

    logic [15:0] sramAddr;
    logic [15:0] sramWdata;
    logic [15:0] sramRdata;
    logic        sramEn;
    logic        sramWr;
    logic        sramOe;

    modport master (
        output ifReq, ifAddr, memReq, memWr, memAddr, memWdata,
        output dbgReq, dbgWr, dbgAddr, dbgWdata, sramRdata,
        input  ifRdata, ifAck, memRdata, memAck, dbgRdata, dbgAck,
        input  sramAddr, sramWdata, sramEn, sramWr, sramOe
    );

    modport slave (
        input  ifReq, ifAddr, memReq, memWr, memAddr, memWdata,
        input  dbgReq, dbgWr, dbgAddr, dbgWdata, sramRdata,
        output ifRdata, ifAck, memRdata, memAck, dbgRdata, dbgAck,
        output sramAddr, sramWdata, sramEn, sramWr, sramOe
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter: debug port has absolute priority over the two core requesters.
// Define MEM_ARBITER_RR_EN to round-robin mem/fetch ties; otherwise mem beats fetch.
module mem_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus_io
);
    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
    typedef enum logic [1:0] {WinIf, WinMem, WinDbg} win_e;

    localparam logic [1:0] CntLoad = 2'(ACCESS_CYCLES - 1);

    state_e      state_q;
    win_e        win_q;
    win_e        win_sel;
    logic [1:0]  cnt_q;
    logic        sram_en_q, sram_wr_q, sram_oe_q;
    logic [15:0] sram_addr_q, sram_wdata_q;
    logic        if_ack_q, mem_ack_q, dbg_ack_q;
    logic [15:0] if_rdata_q, mem_rdata_q, dbg_rdata_q;
    logic        any_req;
    logic        sel_wr;
    logic [15:0] sel_addr, sel_wdata;
`ifdef MEM_ARBITER_RR_EN
    logic        rr_last_if_q;  // last core winner was fetch, so mem wins the next tie
`endif

    assign any_req = bus_io.ifReq | bus_io.memReq | bus_io.dbgReq;

    always_comb begin
        win_sel = WinIf;
        if (bus_io.dbgReq) begin
            win_sel = WinDbg;
`ifdef MEM_ARBITER_RR_EN
        end else if (bus_io.memReq && bus_io.ifReq) begin
            win_sel = rr_last_if_q ? WinMem : WinIf;
`endif
        end else if (bus_io.memReq) begin
            win_sel = WinMem;
        end
    end

    always_comb begin
        sel_addr  = bus_io.ifAddr;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        unique case (win_sel)
            WinDbg: begin
                sel_addr  = bus_io.dbgAddr;
                sel_wdata = bus_io.dbgWdata;
                sel_wr    = bus_io.dbgWr;
            end
            WinMem: begin
                sel_addr  = bus_io.memAddr;
                sel_wdata = bus_io.memWdata;
                sel_wr    = bus_io.memWr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            win_q        <= WinIf;
            cnt_q        <= '0;
            sram_en_q    <= 1'b0;
            sram_wr_q    <= 1'b0;
            sram_oe_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            if_ack_q     <= 1'b0;
            mem_ack_q    <= 1'b0;
            dbg_ack_q    <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
`ifdef MEM_ARBITER_RR_EN
            rr_last_if_q <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        win_q        <= win_sel;
                        sram_addr_q  <= sel_addr;
                        sram_wdata_q <= sel_wdata;
                        sram_wr_q    <= sel_wr;
                        sram_oe_q    <= sel_wr;
                        sram_en_q    <= 1'b1;
                        cnt_q        <= CntLoad;
                        state_q      <= StAccess;
`ifdef MEM_ARBITER_RR_EN
                        if (win_sel != WinDbg) rr_last_if_q <= (win_sel == WinIf);
`endif
                    end
                end
                StAccess: begin
                    if (cnt_q == 2'd0) begin
                        sram_en_q <= 1'b0;
                        sram_wr_q <= 1'b0;
                        sram_oe_q <= 1'b0;
                        state_q   <= StDone;
                        // Read data goes straight into the winner's register so it is
                        // valid alongside the ack; writes leave it untouched.
                        unique case (win_q)
                            WinDbg: begin
                                dbg_ack_q <= 1'b1;
                                if (!sram_wr_q) dbg_rdata_q <= bus_io.sramRdata;
                            end
                            WinMem: begin
                                mem_ack_q <= 1'b1;
                                if (!sram_wr_q) mem_rdata_q <= bus_io.sramRdata;
                            end
                            default: begin
                                if_ack_q <= 1'b1;
                                if (!sram_wr_q) if_rdata_q <= bus_io.sramRdata;
                            end
                        endcase
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                StDone: begin
                    if_ack_q  <= 1'b0;
                    mem_ack_q <= 1'b0;
                    dbg_ack_q <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.sramEn    = sram_en_q;
    assign bus_io.sramWr    = sram_wr_q;
    assign bus_io.sramOe    = sram_oe_q;
    assign bus_io.sramAddr  = sram_addr_q;
    assign bus_io.sramWdata = sram_wdata_q;
    assign bus_io.ifAck     = if_ack_q;
    assign bus_io.memAck    = mem_ack_q;
    assign bus_io.dbgAck    = dbg_ack_q;
    assign bus_io.ifRdata   = if_rdata_q;
    assign bus_io.memRdata  = mem_rdata_q;
    assign bus_io.dbgRdata  = dbg_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked against a
// transaction-timeline model (grant cycle, strobe window, ack cycle) kept in the bench.
module tb_mem_arbiter;
    localparam int AC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sram_rd;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter_if bus1 ();
    mem_arbiter_if bus4 ();

    assign bus.sramRdata = sram_rd;

    mem_arbiter #(.ACCESS_CYCLES(AC)) u_dut  (.clk(clk), .rst(rst), .bus_io(bus));
    mem_arbiter #(.ACCESS_CYCLES(1))  u_dut1 (.clk(clk), .rst(rst), .bus_io(bus1));
    mem_arbiter #(.ACCESS_CYCLES(4))  u_dut4 (.clk(clk), .rst(rst), .bus_io(bus4));

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Model: at most one transaction in flight, described by when it was granted.
    bit          g_act;
    bit          g_wr;
    int          g_start;
    int          g_who;  // 0 fetch, 1 mem, 2 dbg
    logic [15:0] g_addr, g_wdata;
    int          next_free;
    logic [15:0] m_addr, m_wdata;
    logic [15:0] m_rdata [3];
    bit          rr_last_if;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_acks();  // {dbg, mem, fetch}
        logic [2:0] a;
        a = 3'b000;
        if (g_act && cyc == g_start + AC + 1) a[g_who] = 1'b1;
        return a;
    endfunction

    function automatic logic exp_en();
        return g_act && cyc > g_start && cyc <= g_start + AC;
    endfunction

    task automatic model_eval();
        logic [2:0] r;
        int w;
        if (rst) begin
            g_act = 0; next_free = cyc + 1; m_addr = '0; m_wdata = '0;
            foreach (m_rdata[k]) m_rdata[k] = '0;
            rr_last_if = 1;
            return;
        end
        if (g_act && cyc == g_start + AC && !g_wr) m_rdata[g_who] = sram_rd;
        if (g_act && cyc == g_start + AC + 1) g_act = 0;
        r = {bus.dbgReq, bus.memReq, bus.ifReq};
        if (!g_act && cyc >= next_free && r != 3'b000) begin
            if (r[2]) w = 2;
            else if (r[1] && r[0]) begin
`ifdef MEM_ARBITER_RR_EN
                w = rr_last_if ? 1 : 0;
`else
                w = 1;
`endif
            end else if (r[1]) w = 1;
            else w = 0;
            case (w)
                0: begin g_addr = bus.ifAddr; g_wr = 0; g_wdata = '0; end
                1: begin g_addr = bus.memAddr; g_wr = bus.memWr; g_wdata = bus.memWdata; end
                default: begin g_addr = bus.dbgAddr; g_wr = bus.dbgWr; g_wdata = bus.dbgWdata; end
            endcase
            g_act = 1; g_start = cyc; g_who = w; next_free = cyc + AC + 2;
            m_addr = g_addr; m_wdata = g_wdata;
            if (w != 2) rr_last_if = (w == 0);
        end
    endtask

    task automatic check_outputs();
        logic [2:0] a;
        logic       en;
        a  = exp_acks();
        en = exp_en();
        check("strobes", {13'd0, bus.sramEn, bus.sramWr, bus.sramOe},
              {13'd0, en, en & g_wr, en & g_wr});
        check("acks", {13'd0, bus.dbgAck, bus.memAck, bus.ifAck}, {13'd0, a});
        check("sramAddr", bus.sramAddr, m_addr);
        check("sramWdata", bus.sramWdata, m_wdata);
        check("ifRdata", bus.ifRdata, m_rdata[0]);
        check("memRdata", bus.memRdata, m_rdata[1]);
        check("dbgRdata", bus.dbgRdata, m_rdata[2]);
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic clear_inputs();
        bus.ifReq = 0; bus.ifAddr = '0;
        bus.memReq = 0; bus.memWr = 0; bus.memAddr = '0; bus.memWdata = '0;
        bus.dbgReq = 0; bus.dbgWr = 0; bus.dbgAddr = '0; bus.dbgWdata = '0;
    endtask

    initial begin
        int t_dbg, t_if, n, acks, en1, en4, last1, last4, ack1, ack4;
        logic [15:0] seq;
        bit          req [3];
        bit          wr [3];
        logic [15:0] addr [3], wdata [3];
        logic [2:0]  an;

        clear_inputs();
        bus1.ifReq = 0; bus1.ifAddr = '0; bus1.memReq = 0; bus1.memWr = 0;
        bus1.memAddr = 16'h0011; bus1.memWdata = '0; bus1.dbgReq = 0; bus1.dbgWr = 0;
        bus1.dbgAddr = '0; bus1.dbgWdata = '0; bus1.sramRdata = 16'h1111;
        bus4.ifReq = 0; bus4.ifAddr = '0; bus4.memReq = 0; bus4.memWr = 0;
        bus4.memAddr = 16'h0044; bus4.memWdata = '0; bus4.dbgReq = 0; bus4.dbgWr = 0;
        bus4.dbgAddr = '0; bus4.dbgWdata = '0; bus4.sramRdata = 16'h4444;
        sram_rd = '0;
        rst = 1;
        cycle();
        cycle();
        rst = 0;

        // Single mem read: strobe in cycles 1-2, ack with data in cycle 3.
        bus.memReq = 1; bus.memWr = 0; bus.memAddr = 16'h1234; sram_rd = 16'hBEEF;
        cycle(); check("rd_en_c1", 16'(bus.sramEn), 16'd1);
        check("rd_addr", bus.sramAddr, 16'h1234);
        cycle(); check("rd_en_c2", 16'(bus.sramEn), 16'd1);
        cycle(); check("rd_ack_c3", 16'(bus.memAck), 16'd1);
        check("rd_data_c3", bus.memRdata, 16'hBEEF);
        bus.memReq = 0;
        cycle();

        // Debug write against a simultaneous fetch.
        bus.dbgReq = 1; bus.dbgWr = 1; bus.dbgAddr = 16'h0040; bus.dbgWdata = 16'h00FF;
        bus.ifReq = 1; bus.ifAddr = 16'h0100; sram_rd = 16'h5A5A;
        cycle();
        check("dbg_wr", 16'(bus.sramWr), 16'd1);
        check("dbg_oe", 16'(bus.sramOe), 16'd1);
        check("dbg_wdata", bus.sramWdata, 16'h00FF);
        t_dbg = -1; t_if = -1;
        for (int i = 0; i < 16 && t_if < 0; i++) begin
            cycle();
            if (bus.dbgAck) begin t_dbg = cyc; bus.dbgReq = 0; end
            if (bus.ifAck) begin t_if = cyc; bus.ifReq = 0; end
        end
        check("dbg_if_gap", 16'(t_if - t_dbg), 16'd4);
        check("if_after_dbg_seen", 16'(t_if > 0), 16'd1);
        clear_inputs();
        cycle();

        // Both core requesters held high from a fresh reset.
        rst = 1; cycle(); rst = 0;
        bus.memReq = 1; bus.ifReq = 1; bus.memAddr = 16'h0200; bus.ifAddr = 16'h0300;
        seq = '0; n = 0;
        for (int i = 0; i < 30 && n < 4; i++) begin
            cycle();
            if (bus.memAck) begin seq = {seq[11:0], 4'h1}; n++; end
            if (bus.ifAck)  begin seq = {seq[11:0], 4'h2}; n++; end
        end
`ifdef MEM_ARBITER_RR_EN
        check("core_order", seq, 16'h1212);
`else
        check("core_order", seq, 16'h1111);
`endif
        clear_inputs();
        cycle(); cycle(); cycle(); cycle();

        // Reset in the second access cycle aborts without an ack.
        bus.memReq = 1; bus.memWr = 0; bus.memAddr = 16'h2222;
        cycle(); cycle();
        rst = 1; bus.memReq = 0;
        cycle();
        check("abort_en", 16'(bus.sramEn), 16'd0);
        rst = 0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            acks += int'(bus.memAck) + int'(bus.ifAck) + int'(bus.dbgAck);
        end
        check("abort_no_ack", 16'(acks), 16'd0);
        bus.dbgReq = 1; bus.dbgWr = 0; bus.dbgAddr = 16'h3333;
        cycle();
        check("idle_after_abort", 16'(bus.sramEn), 16'd1);
        bus.dbgReq = 0;
        for (int i = 0; i < 4; i++) cycle();

        // Request dropped in the first access cycle still completes once.
        bus.memReq = 1; bus.memWr = 1; bus.memAddr = 16'h4444; bus.memWdata = 16'hCAFE;
        cycle();
        bus.memReq = 0; bus.memAddr = 16'hFFFF; bus.memWdata = 16'h0000;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            acks += int'(bus.memAck);
        end
        check("drop_one_ack", 16'(acks), 16'd1);

        // Strobe length at the range ends of the access parameter.
        bus1.memReq = 1; bus4.memReq = 1;
        en1 = 0; en4 = 0; last1 = -1; last4 = -1; ack1 = -100; ack4 = -100;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (bus1.sramEn) begin en1++; last1 = cyc; end
            if (bus4.sramEn) begin en4++; last4 = cyc; end
            if (bus1.memAck) begin ack1 = cyc; bus1.memReq = 0; end
            if (bus4.memAck) begin ack4 = cyc; bus4.memReq = 0; end
        end
        check("ac1_en_len", 16'(en1), 16'd1);
        check("ac4_en_len", 16'(en4), 16'd4);
        check("ac1_ack_lat", 16'(ack1 - last1), 16'd1);
        check("ac4_ack_lat", 16'(ack4 - last4), 16'd1);
        check("ac1_rdata", bus1.memRdata, 16'h1111);
        check("ac4_rdata", bus4.memRdata, 16'h4444);

        // Random traffic; requesters drop on their (model-predicted) ack.
        for (int k = 0; k < 3; k++) begin
            req[k] = 0; wr[k] = 0; addr[k] = '0; wdata[k] = '0;
        end
        for (int i = 0; i < 4000; i++) begin
            an = exp_acks();
            for (int k = 0; k < 3; k++) begin
                if (req[k] && an[k]) begin
                    req[k] = ($urandom_range(0, 3) == 0);
                end else if (!req[k] && $urandom_range(0, (k == 2) ? 11 : 2) == 0) begin
                    req[k] = 1; wr[k] = (k != 0) && $urandom_range(0, 1) == 1;
                    addr[k] = 16'($urandom); wdata[k] = 16'($urandom);
                end else if (req[k] && $urandom_range(0, 19) == 0) begin
                    req[k] = 0;
                end
                if ($urandom_range(0, 7) == 0) begin
                    addr[k] = 16'($urandom); wdata[k] = 16'($urandom);
                end
            end
            bus.ifReq = req[0]; bus.ifAddr = addr[0];
            bus.memReq = req[1]; bus.memWr = wr[1]; bus.memAddr = addr[1];
            bus.memWdata = wdata[1];
            bus.dbgReq = req[2]; bus.dbgWr = wr[2]; bus.dbgAddr = addr[2];
            bus.dbgWdata = wdata[2];
            sram_rd = 16'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, SRAM strobe length in clk cycles; legal range 1-4.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ifReq  input  1  instruction-fetch read request; held until ifAck.
REQ-005 ifAddr  input  16  fetch word address.
REQ-006 ifRdata  output  16  fetch read data; valid in the cycle ifAck is high.
REQ-007 ifAck  output  1  one-cycle completion pulse to fetch.
REQ-008 memReq / memWr  input  1 / 1  data-access request, and write (1) or read (0).
REQ-009 memAddr / memWdata  input  16 / 16  data-access address and write data.
REQ-010 memRdata / memAck  output  16 / 1  data-access read data and completion pulse.
REQ-011 dbgReq / dbgWr  input  1 / 1  debug-port request, and write (1) or read (0).
REQ-012 dbgAddr / dbgWdata  input  16 / 16  debug-port address and write data.
REQ-013 dbgRdata / dbgAck  output  16 / 1  debug-port read data and completion pulse.
REQ-014 sramAddr / sramWdata  output  16 / 16  registered SRAM address and write data.
REQ-015 sramRdata  input  16  SRAM read data.
REQ-016 sramEn / sramWr / sramOe  output  1 / 1 / 1  SRAM chip enable, write strobe, and write-data drive enable (sramOe = sramEn & sramWr).

Function
REQ-017 FSM states: IDLE, ACCESS, DONE; every output is registered.
REQ-018 IDLE: when any request is high, latch winner, address, wr, and wdata, load counter with ACCESS_CYCLES-1, and go to ACCESS; otherwise stay.
REQ-019 Priority: dbg > core; with the Configuration macro off, core priority is mem > if.
REQ-020 ACCESS: sramEn=1, sramWr=latched wr, sramAddr/sramWdata=latched values; decrement counter; at 0, capture sramRdata (on reads) and go to DONE.
REQ-021 DONE: sramEn=0, winner's ack=1 for exactly one cycle, winner's rdata=captured value (last write leaves it unchanged); next state IDLE.
REQ-022 Latency: req high in IDLE cycle T -> sramEn high in cycles T+1..T+ACCESS_CYCLES -> ack in cycle T+ACCESS_CYCLES+1; minimum spacing between grants is ACCESS_CYCLES+2 cycles.
REQ-023 Requester deasserts req the cycle after ack; req still high in the following IDLE counts as a new request.
REQ-024 Request dropped mid-access is ignored: access completes and ack still pulses once.
REQ-025 Request inputs changing during ACCESS/DONE do not alter latched address, data, or wr.
REQ-026 At most one ack is high in any cycle; non-winning requests wait with no ack.
REQ-027 Each rdata output holds its last value until that requester's next read ack.
REQ-028 dbg may starve core indefinitely (core is paused during debug); core requesters never starve each other when the Configuration macro is on.

Reset
REQ-029 rst high at an edge: state=IDLE, counter=0, all outputs 0 (sramEn, sramWr, sramOe, acks, sramAddr, sramWdata, rdata regs), round-robin pointer favours mem.
REQ-030 Reset during ACCESS aborts the access: sramEn=0 next cycle and no ack for the aborted request.

Configuration
REQ-031 MEM_ARBITER_RR_EN defined: core arbitration is round-robin; a 1-bit pointer records the last core winner, the other core requester wins a tie, and dbg keeps absolute priority.
REQ-032 MEM_ARBITER_RR_EN undefined: fixed priority dbg > mem > if; pointer logic absent.

Verification
REQ-033 ACCESS_CYCLES=2, memReq read of 0x1234 (SRAM returns 0xBEEF) in cycle 0 -> sramEn high in cycles 1-2, memAck and memRdata=0xBEEF in cycle 3.
REQ-034 dbgReq write 0x00FF->0x0040 simultaneous with ifReq -> dbg granted first (sramWr=1, sramOe=1, sramWdata=0x00FF); ifAck arrives 4 cycles after dbgAck.
REQ-035 ifReq and memReq held continuously with RR on -> acks alternate mem, if, mem, if; with RR off -> only memAck pulses.
REQ-036 rst pulsed in the second ACCESS cycle -> sramEn=0 the next cycle, no ack, FSM in IDLE.
REQ-037 memReq dropped in the first ACCESS cycle -> access still completes and memAck pulses once.
REQ-038 ACCESS_CYCLES=1 and 4 -> sramEn high for exactly 1 and 4 cycles respectively; ack follows one cycle later.
